// File: rtl/dwconv_pkg.sv
// Shared definitions for the depthwise-conv frame scheduler.
package dwconv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   // Address width for a memory of 'depth' words, never narrower than 1 bit.
   function automatic int addr_width(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

   // Width needed to hold the values 0..max_val inclusive.
   function automatic int count_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/dwconv_sched_cnt.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module dwconv_sched_cnt #(
   parameter int W   = 6,
   parameter int MAX = 35
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         at_max
);

   assign at_max = (cnt == W'(MAX));

   // Clear wins over increment; increment stops at MAX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_max) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dwconv_sched.sv
// Frame scheduler for the depthwise-conv datapath: streams one input frame
// from feature memory and supervises the datapath's output count.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing one read per cycle, addresses 0..INPUT_SIZE^2-1
// DRAIN | reads finished, waiting for conv_dout_end (bounded by TIMEOUT)
// DONE  | one-cycle completion pulse
// ERR   | sticky fault; start restarts a frame exactly as in IDLE
module dwconv_sched
   import dwconv_pkg::*;
#(
   parameter  int N             = 16,
   parameter  int INPUT_CHANNEL = 3,
   parameter  int INPUT_SIZE    = 6,
   parameter  int OUTPUT_SIZE   = 6,
   parameter  int TIMEOUT       = 1024,
   localparam int AW            = addr_width(INPUT_SIZE * INPUT_SIZE),
   localparam int OW            = count_width(OUTPUT_SIZE * OUTPUT_SIZE),
   localparam int DW            = INPUT_CHANNEL * N
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic          conv_input_vld,
   output logic [DW-1:0] conv_input_din,
   input  logic          conv_dout_vld,
   input  logic          conv_dout_end,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [OW-1:0] out_count
);

   localparam int PIX  = INPUT_SIZE * INPUT_SIZE;
   localparam int OUTS = OUTPUT_SIZE * OUTPUT_SIZE;
   localparam int TW   = count_width(TIMEOUT);

   state_t          state;
   logic [TW-1:0]   tmo;
   logic            start_ok;
   logic            addr_last;
   logic            out_inc;
   logic            out_sat;
   logic [OW-1:0]   out_incl;

   assign start_ok = start && ((state == ST_IDLE) || (state == ST_ERR));
   assign out_inc  = busy && conv_dout_vld;
   // Count as it will be after this cycle's vld, used to judge conv_dout_end.
   assign out_incl = (out_inc && !out_sat) ? out_count + 1'b1 : out_count;

   dwconv_sched_cnt #(
      .W   (AW),
      .MAX (PIX - 1)
   ) u_addr_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_ok),
      .inc    (state == ST_FETCH),
      .cnt    (mem_addr),
      .at_max (addr_last)
   );

   dwconv_sched_cnt #(
      .W   (OW),
      .MAX (OUTS)
   ) u_out_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_ok),
      .inc    (out_inc),
      .cnt    (out_count),
      .at_max (out_sat)
   );

   // Frame sequencing with registered strobes and the DRAIN timeout down-counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         mem_rd_en <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         tmo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_ERR: begin
               if (start) begin
                  state     <= ST_FETCH;
                  mem_rd_en <= 1'b1;
                  busy      <= 1'b1;
                  err       <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (conv_dout_end) begin
                  // The datapath cannot legitimately finish before it has the whole frame.
                  state     <= ST_ERR;
                  mem_rd_en <= 1'b0;
                  busy      <= 1'b0;
                  err       <= 1'b1;
               end else if (addr_last) begin
                  state     <= ST_DRAIN;
                  mem_rd_en <= 1'b0;
                  tmo       <= TW'(TIMEOUT - 1);
               end
            end
            ST_DRAIN: begin
               if (conv_dout_end) begin
                  busy <= 1'b0;
                  if (out_incl == OW'(OUTS)) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_ERR;
                     err   <= 1'b1;
                  end
               end else if (tmo == '0) begin
                  state <= ST_ERR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else begin
                  tmo <= tmo - 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state     <= ST_IDLE;
               mem_rd_en <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Read data arrives one cycle after the strobe, so vld is the strobe delayed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_input_vld <= 1'b0;
      end else begin
         conv_input_vld <= mem_rd_en;
      end
   end

   assign conv_input_din = conv_input_vld ? mem_rdata : '0;

endmodule

// File: tb/tb_dwconv_sched.sv
// Directed + randomized bench for dwconv_sched with a frame-level reference model.
module tb_dwconv_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mem_rd_en;
   logic [5:0]  mem_addr;
   logic [47:0] mem_rdata;
   logic        conv_input_vld;
   logic [47:0] conv_input_din;
   logic        conv_dout_vld;
   logic        conv_dout_end;
   logic        busy;
   logic        done;
   logic        err;
   logic [5:0]  out_count;

   logic [47:0] mem_arr [36];

   int checks = 0;
   int errors = 0;

   // monitor state (written only by the monitor)
   int cyc = 0;
   int rd_n = 0;
   int vld_n = 0;
   int din_err = 0;
   int done_n = 0;
   int fall_cyc = 0;
   int err_cyc = 0;
   int prev_addr = 0;
   bit prev_rd = 0;
   bit prev_err = 0;
   int addr_log[$];

   // snapshots (written only by the stimulus)
   int base_rd, base_addr, base_vld, base_din, base_done;

   dwconv_sched #(
      .N             (16),
      .INPUT_CHANNEL (3),
      .INPUT_SIZE    (6),
      .OUTPUT_SIZE   (6),
      .TIMEOUT       (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .conv_input_vld (conv_input_vld),
      .conv_input_din (conv_input_din),
      .conv_dout_vld  (conv_dout_vld),
      .conv_dout_end  (conv_dout_end),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .out_count      (out_count)
   );

   always #5 clk = ~clk;

   // feature memory model: one-cycle read latency
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];
   end

   // monitor: sample away from the active edge and accumulate frame statistics
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_rd_en) begin
         rd_n = rd_n + 1;
         addr_log.push_back(int'(mem_addr));
      end
      if (conv_input_vld) begin
         vld_n = vld_n + 1;
         if (conv_input_din !== mem_arr[prev_addr]) din_err = din_err + 1;
      end else if (conv_input_din !== 48'd0) begin
         din_err = din_err + 1;
      end
      if (done === 1'b1) done_n = done_n + 1;
      if (prev_rd && !mem_rd_en) fall_cyc = cyc;
      if (!prev_err && err) err_cyc = cyc;
      prev_rd   = mem_rd_en;
      prev_err  = err;
      prev_addr = int'(mem_addr);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit fetched();
      return ((rd_n - base_rd) >= 36) && !mem_rd_en;
   endfunction

   task automatic snapshot();
      base_rd   = rd_n;
      base_addr = addr_log.size();
      base_vld  = vld_n;
      base_din  = din_err;
      base_done = done_n;
   endtask

   task automatic start_pulse();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // datapath model: n_vld output strobes with a few random gaps; the final
   // strobe optionally carries end and is held back until reads are finished
   task automatic drive_dp(input int n_vld, input bit send_end, input bit spam);
      int budget;
      int k;
      budget = 8;
      for (int i = 0; i < n_vld; i++) begin
         int gap;
         if (spam) gap = (i == 5 || i == 20) ? 1 : 0;
         else      gap = (budget > 0) ? int'($urandom_range(1, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            budget--;
            start = spam && ((rd_n - base_rd) < 30);
            @(posedge clk); #1;
            start = 1'b0;
         end
         if (send_end && i == n_vld - 1) begin
            k = 0;
            while (!fetched() && k < 100) begin
               @(posedge clk); #1;
               k++;
            end
            chk("fetch_wait", 64'(fetched()), 64'd1);
         end
         conv_dout_vld = 1'b1;
         conv_dout_end = send_end && (i == n_vld - 1);
         @(posedge clk); #1;
         conv_dout_vld = 1'b0;
         conv_dout_end = 1'b0;
      end
   endtask

   // reference model: each frame is a single 0..35 address run, 36 vld
   // cycles carrying the addressed memory words, and the given outcome
   task automatic check_frame(input string tag, input int exp_done, input bit exp_err,
                              input int exp_cnt);
      int mis;
      mis = 0;
      for (int j = 0; j < 36; j++) begin
         if (base_addr + j >= addr_log.size()) mis++;
         else if (addr_log[base_addr + j] != j) mis++;
      end
      chk({tag, "_addr_seq"},  64'(mis), 64'd0);
      chk({tag, "_rd_count"},  64'(rd_n - base_rd), 64'd36);
      chk({tag, "_vld_count"}, 64'(vld_n - base_vld), 64'd36);
      chk({tag, "_din"},       64'(din_err - base_din), 64'd0);
      chk({tag, "_done"},      64'(done_n - base_done), 64'(exp_done));
      chk({tag, "_err"},       64'(err), 64'(exp_err));
      chk({tag, "_out_count"}, 64'(out_count), 64'(exp_cnt));
      chk({tag, "_busy"},      64'(busy), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rd_en"},  64'(mem_rd_en), 64'd0);
      chk({tag, "_addr"},   64'(mem_addr), 64'd0);
      chk({tag, "_vld"},    64'(conv_input_vld), 64'd0);
      chk({tag, "_din"},    64'(conv_input_din), 64'd0);
      chk({tag, "_busy"},   64'(busy), 64'd0);
      chk({tag, "_done"},   64'(done), 64'd0);
      chk({tag, "_err"},    64'(err), 64'd0);
      chk({tag, "_outcnt"}, 64'(out_count), 64'd0);
   endtask

   initial begin
      int k;
      bit found;
      for (int i = 0; i < 36; i++) mem_arr[i] = 48'({$urandom(), $urandom()});
      rst           = 1'b1;
      start         = 1'b0;
      conv_dout_vld = 1'b0;
      conv_dout_end = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // no reads until a start arrives
      snapshot();
      repeat (10) @(posedge clk);
      #1;
      chk("no_start_reads", 64'(rd_n - base_rd), 64'd0);

      // nominal frame
      snapshot();
      start_pulse();
      drive_dp(36, 1'b1, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      check_frame("t1", 1, 1'b0, 36);

      // datapath strobes in IDLE are ignored; out_count holds
      snapshot();
      for (int i = 0; i < 3; i++) begin
         conv_dout_vld = 1'b1;
         conv_dout_end = 1'b1;
         @(posedge clk); #1;
         conv_dout_vld = 1'b0;
         conv_dout_end = 1'b0;
         @(posedge clk); #1;
      end
      chk("idle_hold_count", 64'(out_count), 64'd36);
      chk("idle_no_err", 64'(err), 64'd0);
      chk("idle_no_done", 64'(done_n - base_done), 64'd0);

      // start while busy is ignored
      snapshot();
      start_pulse();
      drive_dp(36, 1'b1, 1'b1);
      repeat (30) @(posedge clk);
      #1;
      check_frame("t2", 1, 1'b0, 36);

      // end after only 35 outputs
      snapshot();
      start_pulse();
      drive_dp(35, 1'b1, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      check_frame("t3", 0, 1'b1, 35);

      // restart from ERR
      snapshot();
      start_pulse();
      chk("t6_err_cleared", 64'(err), 64'd0);
      chk("t6_busy", 64'(busy), 64'd1);
      drive_dp(36, 1'b1, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      check_frame("t6", 1, 1'b0, 36);

      // datapath never ends: timeout 16 cycles after DRAIN entry
      snapshot();
      start_pulse();
      drive_dp(36, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      check_frame("t4", 0, 1'b1, 36);
      chk("t4_timeout_cycles", 64'(err_cyc - fall_cyc), 64'd16);

      // reset mid-frame at address 20
      snapshot();
      start_pulse();
      found = 1'b0;
      k = 0;
      while (!found && k < 100) begin
         @(negedge clk);
         if (mem_rd_en && mem_addr == 6'd20) found = 1'b1;
         k++;
      end
      chk("t5_reach_addr20", 64'(found), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("t5_rst");
      @(negedge clk);
      rst = 1'b0;
      snapshot();
      repeat (10) @(posedge clk);
      #1;
      chk("t5_no_reads_after_rst", 64'(rd_n - base_rd), 64'd0);
      snapshot();
      start_pulse();
      drive_dp(36, 1'b1, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      check_frame("t5", 1, 1'b0, 36);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
